toy_mc_cpu: RTL and testbench

TOY_MC_CPU -- requirements
Module: toy_mc_cpu

---
 rtl/toy_mc_cpu_if.sv | 27 ++
 rtl/toy_mc_cpu.sv | 139 +++++++++++++
 tb/tb_toy_mc_cpu.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toy_mc_cpu_if.sv
// toy_mc_cpu_if: instruction fetch and data memory bus
// for the toy multicycle accumulator cpu.
interface toy_mc_cpu_if #(
  parameter int DW = 16,
  parameter int AW = 12
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_we;
  logic [DW-1:0] dmem_wdata;

  modport master (
    output imem_req, imem_addr,
    output dmem_addr, dmem_we, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    input  dmem_addr, dmem_we, dmem_wdata,
    output imem_ack, imem_rdata, dmem_rdata
  );
endinterface

// File: rtl/toy_mc_cpu.sv
// toy_mc_cpu: two-state-per-instruction accumulator cpu,
// fetch with ack handshake, single-cycle execute.
module toy_mc_cpu #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  toy_mc_cpu_if.master  bus,
  output logic [DW-1:0] A,
  output logic [DW-1:0] T,
  output logic [AW-1:0] PC,
  output logic [DW-1:0] ins,
  output logic          C,
  output logic          Z,
  output logic          retire,
  output logic          halted
);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_t;

  state_t state;
  logic   req;

  logic [3:0]    op;
  logic [AW-1:0] opa;
  logic [DW-1:0] mem;
  logic [DW:0]   sum;
  logic [DW:0]   diff;
  logic [AW-1:0] pc_inc;

  assign op     = ins[DW-1:DW-4];
  assign opa    = ins[AW-1:0];
  assign mem    = bus.dmem_rdata;
  assign sum    = {1'b0, A} + {1'b0, mem};
  assign diff   = {1'b0, A} - {1'b0, mem};
  assign pc_inc = PC + AW'(1);

  logic [DW-1:0] a_nxt;
  logic [DW-1:0] t_nxt;
  logic [AW-1:0] pc_nxt;
  logic          c_nxt;
  logic          a_wr;

  always_comb begin
    a_nxt  = A;
    t_nxt  = T;
    c_nxt  = C;
    a_wr   = 1'b0;
    pc_nxt = pc_inc;
    case (op)
      4'h0: pc_nxt = PC;
      4'h1: begin
        a_nxt = mem;
        a_wr  = 1'b1;
      end
      4'h3: begin
        {c_nxt, a_nxt} = sum;
        a_wr = 1'b1;
      end
      4'h4: begin
        {c_nxt, a_nxt} = diff;
        a_wr = 1'b1;
      end
      4'h5: begin
        a_nxt = A & mem;
        a_wr  = 1'b1;
      end
      4'h6: begin
        a_nxt = A ^ mem;
        a_wr  = 1'b1;
      end
      4'h7: t_nxt = A;
      4'h8: pc_nxt = opa;
      4'h9: pc_nxt = Z ? opa : pc_inc;
      4'hA: pc_nxt = C ? opa : pc_inc;
      4'hB: pc_nxt = mem[AW-1:0];
      default: ;
    endcase
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = PC;
  assign bus.dmem_addr  = opa;
  assign bus.dmem_wdata = A;
  // Gated by rst_n so a reset landing on a store drops the write.
  assign bus.dmem_we    = rst_n && (state == EXEC) && (op == 4'h2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= FETCH;
      req    <= 1'b1;
      PC     <= '0;
      A      <= '0;
      T      <= '0;
      ins    <= '0;
      C      <= 1'b0;
      Z      <= 1'b1;
      retire <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          retire <= 1'b0;
          if (bus.imem_ack) begin
            ins   <= bus.imem_rdata;
            req   <= 1'b0;
            state <= EXEC;
          end
        end
        EXEC: begin
          retire <= 1'b1;
          PC     <= pc_nxt;
          A      <= a_nxt;
          T      <= t_nxt;
          C      <= c_nxt;
          if (a_wr) Z <= (a_nxt == '0);
          if (op == 4'h0) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            req   <= 1'b1;
            state <= FETCH;
          end
        end
        HALT: retire <= 1'b0;
        default: begin
          req   <= 1'b1;
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toy_mc_cpu.sv
// tb_toy_mc_cpu: scoreboard bench, ISA-level reference model,
// directed programs plus randomized programs and fetch latency.
module tb_toy_mc_cpu;
  localparam int DW = 16;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] A, T, ins;
  logic [AW-1:0] PC;
  logic C, Z, retire, halted;

  toy_mc_cpu_if #(.DW(DW), .AW(AW)) bus ();

  toy_mc_cpu #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .A(A), .T(T), .PC(PC), .ins(ins),
    .C(C), .Z(Z), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] imem [4096];
  logic [DW-1:0] dmem [4096];
  int mim [4096];
  int mdm [4096];

  assign bus.dmem_rdata = dmem[bus.dmem_addr];
  always @(posedge clk) if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;

  typedef struct { int pc; int a; int t; int c; int z; } exp_t;
  typedef struct { int ad; int d; } wr_t;
  exp_t sbq [$];
  wr_t  wq [$];

  int tests = 0;
  int fails = 0;
  int nret = 0;
  int nwr = 0;
  int mode = 0;
  bit spur = 0;
  int cnt = 0;
  int dly = 0;

  function automatic void chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void miss(string nm);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none/other", nm);
  endfunction

  function automatic int new_dly();
    if (mode == 0) return 0;
    if (mode == 1) return 3;
    return int'($urandom_range(0, 3));
  endfunction

  // fetch responder: drives at negedge+1
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      cnt = 0;
      bus.imem_ack = 1'($urandom);
      bus.imem_rdata = 16'($urandom);
    end else if (bus.imem_req) begin
      if (cnt >= dly) begin
        bus.imem_ack = 1'b1;
        bus.imem_rdata = imem[bus.imem_addr];
        cnt = 0;
        dly = new_dly();
      end else begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 16'($urandom);
        cnt++;
      end
    end else begin
      cnt = 0;
      bus.imem_ack = spur && ($urandom_range(0, 3) == 0);
      bus.imem_rdata = 16'($urandom);
    end
  end

  // monitor: samples at negedge+2
  exp_t me;
  wr_t mw;
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;
  logic prev_rst = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always begin
    @(negedge clk);
    #2;
    if (retire) begin
      nret++;
      if (sbq.size() == 0) miss("unexpected_retire");
      else begin
        me = sbq.pop_front();
        chk("ret_pc", int'(PC), me.pc);
        chk("ret_a", int'(A), me.a);
        chk("ret_t", int'(T), me.t);
        chk("ret_c", int'(C), me.c);
        chk("ret_z", int'(Z), me.z);
      end
    end
    if (bus.dmem_we) begin
      nwr++;
      if (wq.size() == 0) miss("unexpected_write");
      else begin
        mw = wq.pop_front();
        chk("wr_addr", int'(bus.dmem_addr), mw.ad);
        chk("wr_data", int'(bus.dmem_wdata), mw.d);
      end
    end
    if (halted) begin
      chk("halt_req", int'(bus.imem_req), 0);
      chk("halt_we", int'(bus.dmem_we), 0);
    end
    if (rst_n && prev_rst && bus.imem_req && prev_req && !prev_ack)
      chk("fetch_addr_stable", int'(bus.imem_addr), int'(prev_addr));
    prev_req = bus.imem_req;
    prev_ack = bus.imem_ack;
    prev_addr = bus.imem_addr;
    prev_rst = rst_n;
  end

  // ISA-level reference: interprets the program from the memory copies
  task automatic model(int steps);
    int pc = 0, a = 0, t = 0, c = 0, z = 1;
    int w, op, ad, m;
    exp_t e;
    wr_t wr;
    for (int i = 0; i < 4096; i++) begin
      mim[i] = int'(imem[i]);
      mdm[i] = int'(dmem[i]);
    end
    for (int s = 0; s < steps; s++) begin
      w = mim[pc];
      op = w >> 12;
      ad = w & 'hFFF;
      m = mdm[ad];
      case (op)
        1: a = m;
        2: begin
          wr.ad = ad;
          wr.d = a;
          wq.push_back(wr);
          mdm[ad] = a;
        end
        3: begin
          a = a + m;
          c = a >> 16;
          a = a & 'hFFFF;
        end
        4: begin
          c = (a < m) ? 1 : 0;
          a = (a - m) & 'hFFFF;
        end
        5: a = a & m;
        6: a = a ^ m;
        7: t = a;
        default: ;
      endcase
      if (op == 1 || (op >= 3 && op <= 6)) z = (a == 0) ? 1 : 0;
      case (op)
        0: ;
        8: pc = ad;
        9: pc = (z != 0) ? ad : (pc + 1) % 4096;
        10: pc = (c != 0) ? ad : (pc + 1) % 4096;
        11: pc = m & 'hFFF;
        default: pc = (pc + 1) % 4096;
      endcase
      e.pc = pc; e.a = a; e.t = t; e.c = c; e.z = z;
      sbq.push_back(e);
      if (op == 0) break;
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_pc", int'(PC), 0);
    chk("rst_a", int'(A), 0);
    chk("rst_t", int'(T), 0);
    chk("rst_ir", int'(ins), 0);
    chk("rst_c", int'(C), 0);
    chk("rst_z", int'(Z), 1);
    chk("rst_retire", int'(retire), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_we", int'(bus.dmem_we), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sbq.delete();
    wq.delete();
    @(negedge clk);
    #3;
    check_reset_vals();
  endtask

  task automatic start(int md, bit sp);
    mode = md;
    spur = sp;
    dly = new_dly();
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("req_after_rst", int'(bus.imem_req), 1);
    chk("addr_after_rst", int'(bus.imem_addr), 0);
  endtask

  task automatic run_wait(int bound, output int cyc);
    cyc = 0;
    while ((sbq.size() != 0 || wq.size() != 0) && cyc < bound) begin
      @(negedge clk);
      #3;
      cyc++;
    end
    if (sbq.size() != 0 || wq.size() != 0) miss("run_timeout");
  endtask

  task automatic clr();
    for (int i = 0; i < 4096; i++) begin
      imem[i] = '0;
      dmem[i] = '0;
    end
  endtask

  task automatic frozen();
    int pc0, a0;
    pc0 = int'(PC);
    a0 = int'(A);
    repeat (3) @(negedge clk);
    #3;
    chk("frozen_pc", int'(PC), pc0);
    chk("frozen_a", int'(A), a0);
    chk("frozen_halted", int'(halted), 1);
  endtask

  task automatic prog_add(int md, int cyc_exp);
    int cyc, r0;
    do_reset();
    clr();
    dmem[12'h010] = 16'h0005;
    dmem[12'h011] = 16'hFFFC;
    imem[0] = 16'h1010;
    imem[1] = 16'h3011;
    imem[2] = 16'h0000;
    model(20);
    r0 = nret;
    start(md, 1'b0);
    run_wait(100, cyc);
    chk("add_cycles", cyc, cyc_exp);
    chk("add_retires", nret - r0, 3);
    chk("add_a", int'(A), 16'h0001);
    chk("add_c", int'(C), 1);
    chk("add_z", int'(Z), 0);
    chk("add_pc", int'(PC), 2);
    chk("add_halted", int'(halted), 1);
    frozen();
  endtask

  task automatic prog_sub(int sub, int pc_exp, int a_exp, int c_exp);
    int cyc;
    do_reset();
    clr();
    dmem[12'h030] = 16'h0003;
    dmem[12'h031] = 16'(sub);
    imem[0] = 16'h1030;
    imem[1] = 16'h4031;
    imem[2] = 16'h9020;
    model(20);
    start(0, 1'b1);
    run_wait(100, cyc);
    chk("sub_a", int'(A), a_exp);
    chk("sub_c", int'(C), c_exp);
    chk("sub_z", int'(Z), (a_exp == 0) ? 1 : 0);
    chk("sub_pc", int'(PC), pc_exp);
  endtask

  int cyc;
  int w0;

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    // zero-wait and 3-cycle fetch latency give the same end state
    prog_add(0, 6);
    prog_add(1, 15);
    prog_sub(3, 12'h020, 0, 0);
    prog_sub(4, 3, 16'hFFFF, 1);

    // PC wrap after NOP at 0xFFF, then JMPI through memory
    do_reset();
    clr();
    dmem[12'h041] = 16'hFFFF;
    dmem[12'h042] = 16'hF123;
    imem[0] = 16'hA200;
    imem[1] = 16'h1041;
    imem[2] = 16'h3041;
    imem[3] = 16'h8FFF;
    imem[12'hFFF] = 16'hC000;
    imem[12'h200] = 16'hB042;
    model(40);
    start(2, 1'b1);
    run_wait(300, cyc);
    chk("jmpi_pc", int'(PC), 12'h123);
    chk("jmpi_halted", int'(halted), 1);

    // store then copy to T
    do_reset();
    clr();
    dmem[12'h010] = 16'hBEEF;
    dmem[12'h05A] = 16'h1234;
    imem[0] = 16'h1010;
    imem[1] = 16'h205A;
    imem[2] = 16'h7000;
    model(20);
    w0 = nwr;
    start(0, 1'b0);
    run_wait(100, cyc);
    @(negedge clk);
    #3;
    chk("sta_writes", nwr - w0, 1);
    chk("sta_mem", int'(dmem[12'h05A]), 16'hBEEF);
    chk("tat_t", int'(T), 16'hBEEF);

    // reset landing on the EXEC cycle of the store
    do_reset();
    clr();
    dmem[12'h010] = 16'hBEEF;
    dmem[12'h05A] = 16'h1234;
    imem[0] = 16'h1010;
    imem[1] = 16'h205A;
    imem[2] = 16'h7000;
    model(20);
    w0 = nwr;
    start(1, 1'b0);
    cyc = 0;
    while (!(ins[DW-1:DW-4] == 4'h2 && !bus.imem_req && !halted) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 60) miss("sta_exec_timeout");
    rst_n = 1'b0;
    sbq.delete();
    wq.delete();
    #3;
    chk("we_in_rst", int'(bus.dmem_we), 0);
    @(negedge clk);
    #3;
    check_reset_vals();
    chk("abandoned_mem", int'(dmem[12'h05A]), 16'h1234);
    chk("abandoned_writes", nwr - w0, 0);
    model(20);
    start(0, 1'b0);
    run_wait(100, cyc);

    // randomized programs with random fetch latency and stray acks
    for (int it = 0; it < 25; it++) begin
      do_reset();
      for (int i = 0; i < 4096; i++) begin
        int op, opd, sel;
        op = int'($urandom_range(0, 15));
        opd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                          : int'($urandom_range(0, 63));
        imem[i] = 16'((op << 12) | opd);
        sel = int'($urandom_range(0, 7));
        if (sel == 0) dmem[i] = '0;
        else if (sel < 3) dmem[i] = 16'($urandom_range(1, 8));
        else dmem[i] = 16'($urandom);
      end
      model(60);
      start(int'($urandom_range(0, 2)), 1'b1);
      run_wait(500, cyc);
    end
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
